fpu_driver: RTL and testbench

FPU_DRIVER -- requirements
Module: fpu_driver

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fpu_wdog.sv | 35 +++
 rtl/fpu_driver.sv | 163 ++++++++++++++++
 tb/tb_fpu_driver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared opcodes, driver FSM states and fpu flag-bit positions.
package fpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    LD_SETUP,
    LD_PULSE,
    EXEC,
    GAP,
    RESP
  } state_e;

  localparam int unsigned FLG_LESS     = 0;
  localparam int unsigned FLG_GREAT    = 1;
  localparam int unsigned FLG_EQ       = 2;
  localparam int unsigned FLG_INEXACT  = 3;
  localparam int unsigned FLG_DIV_ZERO = 4;
  localparam int unsigned FLG_INV      = 5;
  localparam int unsigned FLG_UN       = 6;
  localparam int unsigned FLG_OV       = 7;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/fpu_wdog.sv
// Saturating wait counter; expired is high during the LIMIT-th enabled cycle.
module fpu_wdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rstp,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] MAXV = CW'(LIMIT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (enable && (count_q != MAXV))
      count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rstp)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/fpu_driver.sv
// Command/response front end that sequences LOAD and arithmetic operations onto an fpu.
module fpu_driver
  import fpu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstp,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [4:0]       cmd_a,
  input  logic [4:0]       cmd_b,
  input  logic [4:0]       cmd_d,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [2:0]       cmd_round,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [7:0]       rsp_flags,
  output logic             rsp_timeout,
  output logic             rsp_illegal,
  output logic [WIDTH-1:0] fpu_inp,
  output logic [4:0]       fpu_addr1,
  output logic [4:0]       fpu_addr2,
  output logic [4:0]       fpu_addr3,
  output logic [2:0]       fpu_opcode,
  output logic [2:0]       fpu_round,
  output logic             fpu_enable,
  output logic             fpu_ld,
  input  logic [WIDTH-1:0] fpu_out,
  input  logic [7:0]       fpu_flags,
  input  logic             fpu_done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] inp_q, inp_d;
  logic [4:0]       addr1_q, addr1_d;
  logic [4:0]       addr2_q, addr2_d;
  logic [4:0]       addr3_q, addr3_d;
  logic [2:0]       opcode_q, opcode_d;
  logic [2:0]       round_q, round_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0]       rflags_q, rflags_d;
  logic             rtmo_q, rtmo_d;
  logic             rill_q, rill_d;
  logic             wd_clear, wd_expired;

  fpu_wdog #(.LIMIT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rstp    (rstp),
    .clear   (wd_clear),
    .enable  (state_q == EXEC),
    .expired (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    inp_d    = inp_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    addr3_d  = addr3_q;
    opcode_d = opcode_q;
    round_d  = round_q;
    rdata_d  = rdata_q;
    rflags_d = rflags_q;
    rtmo_d   = rtmo_q;
    rill_d   = rill_q;
    wd_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rdata_d  = '0;
          rflags_d = '0;
          rtmo_d   = 1'b0;
          rill_d   = 1'b0;
          if (cmd_op == OP_LOAD) begin
            addr1_d  = cmd_d;
            inp_d    = cmd_data;
            opcode_d = OP_LOAD;
            state_d  = LD_SETUP;
          end else if (is_arith(cmd_op)) begin
            addr1_d  = cmd_a;
            addr2_d  = cmd_b;
            addr3_d  = cmd_d;
            opcode_d = cmd_op;
            round_d  = cmd_round;
            wd_clear = 1'b1;
            state_d  = EXEC;
          end else begin
            rill_d  = 1'b1;
            state_d = RESP;
          end
        end
      end
      LD_SETUP: state_d = LD_PULSE;
      LD_PULSE: state_d = GAP;
      EXEC: begin
        if (fpu_done) begin
          rdata_d  = fpu_out;
          rflags_d = fpu_flags;
          state_d  = GAP;
        end else if (wd_expired) begin
          rtmo_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: state_d = RESP;
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      state_q  <= IDLE;
      inp_q    <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      addr3_q  <= '0;
      opcode_q <= '0;
      round_q  <= '0;
      rdata_q  <= '0;
      rflags_q <= '0;
      rtmo_q   <= 1'b0;
      rill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      inp_q    <= inp_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      addr3_q  <= addr3_d;
      opcode_q <= opcode_d;
      round_q  <= round_d;
      rdata_q  <= rdata_d;
      rflags_q <= rflags_d;
      rtmo_q   <= rtmo_d;
      rill_q   <= rill_d;
    end
  end

  always_comb begin
    cmd_ready   = (state_q == IDLE);
    rsp_valid   = (state_q == RESP);
    fpu_enable  = (state_q == LD_SETUP) || (state_q == LD_PULSE) || (state_q == EXEC);
    fpu_ld      = (state_q == LD_PULSE);
    rsp_data    = rdata_q;
    rsp_flags   = rflags_q;
    rsp_timeout = rtmo_q;
    rsp_illegal = rill_q;
    fpu_inp     = inp_q;
    fpu_addr1   = addr1_q;
    fpu_addr2   = addr2_q;
    fpu_addr3   = addr3_q;
    fpu_opcode  = opcode_q;
    fpu_round   = round_q;
  end

endmodule

// File: tb/tb_fpu_driver.sv
// Directed bench for fpu_driver with a latency-programmable fpu model.
module tb_fpu_driver;
  import fpu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rstp = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [4:0]       cmd_a = '0, cmd_b = '0, cmd_d = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [2:0]       cmd_round = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic [7:0]       rsp_flags;
  logic             rsp_timeout, rsp_illegal;
  logic [WIDTH-1:0] fpu_inp;
  logic [4:0]       fpu_addr1, fpu_addr2, fpu_addr3;
  logic [2:0]       fpu_opcode, fpu_round;
  logic             fpu_enable, fpu_ld;
  logic [WIDTH-1:0] fpu_out = '0;
  logic [7:0]       fpu_flags = '0;
  logic             fpu_done;

  logic model_on   = 1'b0;
  logic force_done = 1'b0;
  int   en_run     = 0;
  int   en_total   = 0;
  int   total      = 0;
  int   bad        = 0;
  int   en_start, lat;

  fpu_driver #(.WIDTH(WIDTH), .TIMEOUT(64)) dut (
    .clk(clk), .rstp(rstp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_data(cmd_data), .cmd_round(cmd_round),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_timeout(rsp_timeout), .rsp_illegal(rsp_illegal),
    .fpu_inp(fpu_inp), .fpu_addr1(fpu_addr1), .fpu_addr2(fpu_addr2), .fpu_addr3(fpu_addr3),
    .fpu_opcode(fpu_opcode), .fpu_round(fpu_round), .fpu_enable(fpu_enable), .fpu_ld(fpu_ld),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags), .fpu_done(fpu_done)
  );

  always #5 clk = ~clk;

  // fpu model: done in the 4th consecutive enabled cycle
  assign fpu_done = force_done || (model_on && fpu_enable && (en_run == 3));

  always @(posedge clk) begin
    en_run   <= fpu_enable ? en_run + 1 : 0;
    en_total <= en_total + (fpu_enable ? 1 : 0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [WIDTH-1:0] data, input logic [2:0] rnd);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_d = d; cmd_data = data; cmd_round = rnd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output int n);
    n = 0;
    while (!rsp_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("rsp_arrives", rsp_valid, 1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    tick(2);
    rstp = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_enable", fpu_enable, 0);
    check("rst_ld", fpu_ld, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_flags_abort", {rsp_flags, rsp_timeout, rsp_illegal}, 0);
    check("rst_fpu_bus", {fpu_inp, fpu_addr1, fpu_addr2, fpu_addr3, fpu_opcode, fpu_round}, 0);

    // stray done while idle
    force_done = 1'b1;
    tick(3);
    check("stray_done_idle", {cmd_ready, rsp_valid, fpu_enable}, 3'b100);
    force_done = 1'b0;

    // LOAD d=0
    issue(OP_LOAD, 5'd0, 5'd0, 5'd0, 32'h3F8CCCCD, 3'd0);
    check("ld_setup_en_ld", {fpu_enable, fpu_ld}, 2'b10);
    check("ld_setup_addr1", fpu_addr1, 0);
    check("ld_setup_inp", fpu_inp, 32'h3F8CCCCD);
    check("ld_setup_opcode", fpu_opcode, OP_LOAD);
    check("ld_busy", cmd_ready, 0);
    tick(1);
    check("ld_pulse_en_ld", {fpu_enable, fpu_ld}, 2'b11);
    tick(1);
    check("ld_gap", {fpu_enable, fpu_ld, rsp_valid}, 3'b000);
    tick(1);
    check("ld_resp_valid", rsp_valid, 1);
    check("ld_resp_data", rsp_data, 0);
    check("ld_resp_flags", rsp_flags, 0);
    ack();
    check("ld_back_idle", {cmd_ready, rsp_valid}, 2'b10);

    // ADD with 4-cycle fpu, then response held for 5 cycles with a LOAD pending
    model_on = 1'b1; fpu_out = 32'hBE4CCCCD; fpu_flags = 8'h08;
    en_start = en_total;
    issue(OP_ADD, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFF, 3'd2);
    check("add_bus", {fpu_addr1, fpu_addr2, fpu_addr3, fpu_opcode, fpu_round}, {5'd0, 5'd1, 5'd2, 3'd0, 3'd2});
    check("add_en_ld", {fpu_enable, fpu_ld}, 2'b10);
    check("add_inp_held", fpu_inp, 32'h3F8CCCCD);
    wait_rsp(20, lat);
    check("add_latency", lat, 5);
    check("add_data", rsp_data, 32'hBE4CCCCD);
    check("add_flags", rsp_flags, 8'h08);
    check("add_abort", {rsp_timeout, rsp_illegal}, 0);
    check("add_en_cycles", en_total - en_start, 4);
    fpu_out = 32'h0; fpu_flags = 8'h0;
    cmd_op = OP_LOAD; cmd_d = 5'd9; cmd_data = 32'h12345678; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("hold_rsp", {rsp_valid, cmd_ready, rsp_data, rsp_flags}, {2'b10, 32'hBE4CCCCD, 8'h08});
    end
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    check("hold_release_idle", {cmd_ready, rsp_valid}, 2'b10);
    tick(1);
    cmd_valid = 1'b0;
    check("pending_ld_accepted", {fpu_enable, fpu_addr1, fpu_inp}, {1'b1, 5'd9, 32'h12345678});
    wait_rsp(10, lat);
    check("pending_ld_data", {rsp_data, rsp_flags}, 0);
    ack();

    // DIV timeout: fpu never completes, bogus output must not be captured
    model_on = 1'b0; fpu_out = 32'hDEADBEEF; fpu_flags = 8'hFF;
    en_start = en_total;
    issue(OP_DIV, 5'd3, 5'd4, 5'd5, 32'h0, 3'd1);
    wait_rsp(200, lat);
    check("div_latency", lat, 65);
    check("div_en_cycles", en_total - en_start, 64);
    check("div_timeout", {rsp_timeout, rsp_illegal}, 2'b10);
    check("div_data", rsp_data, 0);
    check("div_flags", rsp_flags, 0);
    ack();

    model_on = 1'b1; fpu_out = 32'h40490FDB; fpu_flags = 8'h01;
    issue(OP_ADD, 5'd6, 5'd7, 5'd8, 32'h0, 3'd0);
    wait_rsp(20, lat);
    check("add2_result", {rsp_data, rsp_flags, rsp_timeout}, {32'h40490FDB, 8'h01, 1'b0});
    ack();

    // illegal opcode
    en_start = en_total;
    issue(3'b110, 5'd1, 5'd1, 5'd1, 32'h0, 3'd0);
    check("ill_resp", {rsp_valid, rsp_illegal, rsp_timeout}, 3'b110);
    check("ill_data", rsp_data, 0);
    check("ill_no_strobe", en_total - en_start, 0);
    check("ill_bus_held", {fpu_opcode, fpu_addr1}, {OP_ADD, 5'd6});
    ack();

    // reset in the middle of MUL
    model_on = 1'b0;
    issue(OP_MUL, 5'd10, 5'd11, 5'd12, 32'h0, 3'd0);
    check("mul_running", fpu_enable, 1);
    tick(2);
    rstp = 1'b1;
    tick(1);
    rstp = 1'b0;
    check("mul_rst_drop", {fpu_enable, fpu_ld, rsp_valid, cmd_ready}, 4'b0001);
    check("mul_rst_bus", fpu_addr1, 0);
    tick(4);
    check("mul_rst_no_rsp", {rsp_valid, fpu_enable, cmd_ready}, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
